// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
//   mem_state_t : access sequencer states
//   BE_WORD     : byte-enable pattern for a full 32-bit beat
//   byte_be()   : one-hot byte enable for a byte lane
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      DONE  = 2'd3
   } mem_state_t;

   localparam logic [3:0] BE_WORD = 4'b1111;

   function automatic logic [3:0] byte_be(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data formatter.
//   byte_sel   in  : byte load, select lane and sign-extend to 64
//   dbl        in  : double load, assemble two 32-bit beats
//   hi_first   in  : first beat carried the high word of the double
//   lane       in  : byte lane (address bits [1:0]) for byte loads
//   first_word in  : data captured on the first beat of a double
//   rdata      in  : data of the beat completing this cycle
//   load_data  out : formatted 64-bit load value
module mem_load_align (
   input  logic        byte_sel,
   input  logic        dbl,
   input  logic        hi_first,
   input  logic [1:0]  lane,
   input  logic [31:0] first_word,
   input  logic [31:0] rdata,
   output logic [63:0] load_data
);

   logic [7:0] lane_byte;

   always_comb begin
      lane_byte = rdata[7:0];
      case (lane)
         2'd0: lane_byte = rdata[7:0];
         2'd1: lane_byte = rdata[15:8];
         2'd2: lane_byte = rdata[23:16];
         2'd3: lane_byte = rdata[31:24];
         default: lane_byte = rdata[7:0];
      endcase
   end

   always_comb begin
      load_data = '0;
      if (dbl) begin
         load_data = hi_first ? {first_word, rdata} : {rdata, first_word};
      end else if (byte_sel) begin
         load_data = {{56{lane_byte[7]}}, lane_byte};
      end else begin
         load_data = {{32{rdata[31]}}, rdata};
      end
   end

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM-stage access unit: turns an EXE/MEM load/store into one or two beats
// on a 32-bit req/ack data-memory bus, stalls the pipeline until done and
// presents formatted load data to MEM/WB.
//   clk, rst                 : clock, synchronous active-high reset
//   EXE_MEM_*                : pipeline register bundle (address, data, kind)
//   dmem_req/we/addr/wdata/be: beat request, held stable until dmem_ack
//   dmem_ack/rdata           : beat completion and read data (same cycle)
//   MEM_Stall                : freeze upstream stages
//   MEM_LoadData             : formatted load result
//   MEM_Misalign             : pulse when a word/double address was realigned
//
// Handshake: a beat is transferred on a rising edge where dmem_req and
// dmem_ack are both 1; dmem_req and the beat fields do not change until then,
// and dmem_ack while dmem_req is 0 has no effect.
module mem_stage_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter bit DOUBLE_HI_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       EXE_MEM_Result,
   input  logic [63:0]       EXE_MEM_Treg,
   input  logic [63:0]       EXE_MEM_FPTregData,
   input  logic              EXE_MEM_MemRead,
   input  logic              EXE_MEM_MemWrite,
   input  logic              EXE_MEM_Byte,
   input  logic              EXE_MEM_double,
   input  logic              EXE_MEM_FPLoadStore,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              MEM_Stall,
   output logic [63:0]       MEM_LoadData,
   output logic              MEM_Misalign
);

   mem_state_t        state, state_nx;
   logic [ADDR_W-1:0] addr_q;
   logic [63:0]       wdata_q;
   logic              we_q, byte_q, dbl_q;
   logic [1:0]        lane_q;
   logic [31:0]       first_q;
   logic [63:0]       load_data_q;
   logic [63:0]       aligned_data;

   logic              access, dbl_in, byte_in, misalign_in;
   logic [ADDR_W-1:0] addr_in, addr_aligned;
   logic              last_beat, hi_word_sel;

   logic unused_bits;
   assign unused_bits = ^{EXE_MEM_Result[63:ADDR_W], EXE_MEM_Treg[63:32]};

   assign access  = EXE_MEM_MemRead | EXE_MEM_MemWrite;
   assign dbl_in  = EXE_MEM_double & EXE_MEM_FPLoadStore;
   assign byte_in = EXE_MEM_Byte & ~dbl_in;
   assign addr_in = EXE_MEM_Result[ADDR_W-1:0];

   assign misalign_in  = dbl_in ? (addr_in[2:0] != 3'b000)
                                : (~byte_in & (addr_in[1:0] != 2'b00));
   // Beats are always word aligned; a double additionally starts 8-aligned.
   assign addr_aligned = dbl_in ? {addr_in[ADDR_W-1:3], 3'b000}
                                : {addr_in[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      dmem_req = 1'b0;
      case (state)
         IDLE:  if (access) state_nx = BEAT0;
         BEAT0: begin
            dmem_req = 1'b1;
            if (dmem_ack) state_nx = dbl_q ? BEAT1 : DONE;
         end
         BEAT1: begin
            dmem_req = 1'b1;
            if (dmem_ack) state_nx = DONE;
         end
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign last_beat   = (state == BEAT1) | ((state == BEAT0) & ~dbl_q);
   // Which half of the double this beat carries; single-word beats use low.
   assign hi_word_sel = dbl_q & ((state == BEAT1) ^ DOUBLE_HI_FIRST);

   assign dmem_we    = dmem_req & we_q;
   assign dmem_addr  = !dmem_req ? '0 :
                       (state == BEAT1) ? addr_q + ADDR_W'(4) : addr_q;
   assign dmem_wdata = !dmem_req ? 32'd0 :
                       byte_q ? {4{wdata_q[7:0]}} :
                       hi_word_sel ? wdata_q[63:32] : wdata_q[31:0];
   assign dmem_be    = !dmem_req ? 4'd0 : byte_q ? byte_be(lane_q) : BE_WORD;

   // Released in DONE so the EXE/MEM register advances exactly once.
   assign MEM_Stall    = access & (state != DONE);
   assign MEM_Misalign = (state == IDLE) & access & misalign_in;
   assign MEM_LoadData = load_data_q;

   mem_load_align u_align (
      .byte_sel   (byte_q),
      .dbl        (dbl_q),
      .hi_first   (DOUBLE_HI_FIRST),
      .lane       (lane_q),
      .first_word (first_q),
      .rdata      (dmem_rdata),
      .load_data  (aligned_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         byte_q      <= 1'b0;
         dbl_q       <= 1'b0;
         lane_q      <= 2'd0;
         first_q     <= '0;
         load_data_q <= '0;
      end else begin
         if ((state == IDLE) && access) begin
            addr_q  <= addr_aligned;
            wdata_q <= EXE_MEM_FPLoadStore ? EXE_MEM_FPTregData
                                           : {32'd0, EXE_MEM_Treg[31:0]};
            we_q    <= EXE_MEM_MemWrite;
            byte_q  <= byte_in;
            dbl_q   <= dbl_in;
            lane_q  <= addr_in[1:0];
         end
         if ((state == BEAT0) && dmem_ack) begin
            first_q <= dmem_rdata;
         end
         // Result becomes visible in DONE, the cycle MEM/WB captures it.
         if (dmem_req && dmem_ack && last_beat && !we_q) begin
            load_data_q <= aligned_data;
         end
      end
   end

endmodule
